// File: rtl/demux_pkg.sv
// Shared constants and state encodings for the 1:8 demux dispatcher.
package demux_pkg;
  localparam int unsigned N_CH  = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;
endpackage

// File: rtl/demux_rr_pick.sv
// Wrap-around search for the first enabled channel at or after ptr_i.
module demux_rr_pick
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] ptr_i,
  input  logic [N_CH-1:0]  chan_en_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             found_o
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest enabled channel wins.
  always_comb begin
    idx_o   = ptr_i;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      cand = ptr_i + SEL_W'(i - 1);
      if (chan_en_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Single-word holding dispatcher: round-robin or fixed steering onto 8 channels,
// with per-word timeout drop and delivery/drop counters.
module demux_dispatch_ctrl
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              mode,
  input  logic [N_CH-1:0]   chan_en,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  sel,
  output logic              drop,
  output logic [15:0]       deliver_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  tgt_q, tgt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              drop_q, drop_d;
  logic [15:0]       dcnt_q, dcnt_d;
  logic [7:0]        pcnt_q, pcnt_d;

  logic             in_send, out_fire, timeout_hit, accept, any_en;
  logic             acc_ok;
  logic [SEL_W-1:0] ptr_nxt, pick_idx, acc_tgt;
  logic             pick_found;

  assign in_send     = (state_q == SEND);
  assign any_en      = |chan_en;
  assign out_valid   = in_send ? ({{(N_CH-1){1'b0}}, 1'b1} << tgt_q) : '0;
  assign out_fire    = |(out_valid & out_ready);
  assign timeout_hit = in_send && !out_fire && (to_q == TO_W'(TIMEOUT - 1));
  assign in_ready    = (!in_send || out_fire) && any_en;
  assign accept      = in_valid && in_ready;

  // The word accepted alongside a handshake must search from the advanced
  // pointer, otherwise back-to-back round-robin would repeat a channel.
  assign ptr_nxt = ((out_fire || timeout_hit) && (mode_q == MODE_RR) && any_en)
                   ? tgt_q + 1'b1 : ptr_q;

  demux_rr_pick u_pick (
    .ptr_i    (ptr_nxt),
    .chan_en_i(chan_en),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  assign acc_tgt = mode ? in_sel : pick_idx;
  assign acc_ok  = mode ? chan_en[in_sel] : pick_found;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ptr_d   = ptr_nxt;
    tgt_d   = tgt_q;
    data_d  = data_q;
    to_d    = to_q;
    drop_d  = 1'b0;
    dcnt_d  = dcnt_q;
    pcnt_d  = pcnt_q;

    if (in_send) begin
      if (out_fire) begin
        dcnt_d  = dcnt_q + 16'd1;
        to_d    = '0;
        state_d = IDLE;
      end else if (timeout_hit) begin
        drop_d  = 1'b1;
        pcnt_d  = (pcnt_q == 8'hFF) ? pcnt_q : pcnt_q + 8'd1;
        to_d    = '0;
        state_d = IDLE;
      end else begin
        to_d = to_q + 1'b1;
      end
    end

    // Accept only happens in IDLE or alongside out_fire, never with a timeout.
    if (accept) begin
      data_d = in_data;
      tgt_d  = acc_tgt;
      mode_d = mode_e'(mode);
      to_d   = '0;
      if (acc_ok) begin
        state_d = SEND;
      end else begin
        drop_d  = 1'b1;
        pcnt_d  = (pcnt_q == 8'hFF) ? pcnt_q : pcnt_q + 8'd1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_RR;
      ptr_q   <= '0;
      tgt_q   <= '0;
      data_q  <= '0;
      to_q    <= '0;
      drop_q  <= 1'b0;
      dcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ptr_q   <= ptr_d;
      tgt_q   <= tgt_d;
      data_q  <= data_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
      dcnt_q  <= dcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign out_data    = data_q;
  assign sel         = tgt_q;
  assign drop        = drop_q;
  assign deliver_cnt = dcnt_q;
  assign drop_cnt    = pcnt_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed vector bench for demux_dispatch_ctrl (DATA_W=8, TIMEOUT=16).
module tb_demux_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        mode;
  logic [7:0]  chan_en;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [7:0]  out_data;
  logic [2:0]  sel;
  logic        drop;
  logic [15:0] deliver_cnt;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  demux_dispatch_ctrl #(.DATA_W(8), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .mode       (mode),
    .chan_en    (chan_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sel        (sel),
    .drop       (drop),
    .deliver_cnt(deliver_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vi;
    logic [7:0]  d;
    logic [2:0]  isel;
    logic        m;
    logic [7:0]  en;
    logic [7:0]  ordy;
    logic        e_irdy;
    logic [7:0]  e_ov;
    logic [7:0]  e_od;
    logic [2:0]  e_sel;
    logic        e_drop;
    logic [15:0] e_dcnt;
    logic [7:0]  e_pcnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic vi, logic [7:0] d, logic [2:0] isel, logic m,
                              logic [7:0] en, logic [7:0] ordy, logic e_irdy,
                              logic [7:0] e_ov, logic [7:0] e_od, logic [2:0] e_sel,
                              logic e_drop, logic [15:0] e_dcnt, logic [7:0] e_pcnt);
    vec_t v;
    v.vi = vi; v.d = d; v.isel = isel; v.m = m; v.en = en; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_od = e_od; v.e_sel = e_sel;
    v.e_drop = e_drop; v.e_dcnt = e_dcnt; v.e_pcnt = e_pcnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vi, input logic [7:0] d, input logic [2:0] isel,
                       input logic m, input logic [7:0] en, input logic [7:0] ordy);
    in_valid = vi; in_data = d; in_sel = isel; mode = m; chan_en = en; out_ready = ordy;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF, 8'h00);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      drive(tbl[i].vi, tbl[i].d, tbl[i].isel, tbl[i].m, tbl[i].en, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("%s[%0d].in_ready", tag, i), 32'(in_ready), 32'(tbl[i].e_irdy));
      chk($sformatf("%s[%0d].out_valid", tag, i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("%s[%0d].out_data", tag, i), 32'(out_data), 32'(tbl[i].e_od));
      chk($sformatf("%s[%0d].sel", tag, i), 32'(sel), 32'(tbl[i].e_sel));
      chk($sformatf("%s[%0d].drop", tag, i), 32'(drop), 32'(tbl[i].e_drop));
      chk($sformatf("%s[%0d].deliver_cnt", tag, i), 32'(deliver_cnt), 32'(tbl[i].e_dcnt));
      chk($sformatf("%s[%0d].drop_cnt", tag, i), 32'(drop_cnt), 32'(tbl[i].e_pcnt));
      step();
    end
  endtask

  initial begin
    int n;
    logic held_ok;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF, 8'h00);
    #2;
    chk("reset.out_valid", 32'(out_valid), 32'h0);
    chk("reset.deliver_cnt", 32'(deliver_cnt), 32'h0);
    do_reset();

    // Round-robin, back-to-back: one delivery per cycle on channels 0..7 then 0.
    tbl.delete();
    tbl.push_back(mk(1, 8'h10, 0, 0, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 3'd0, 0, 16'd0, 8'd0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1, 8'(8'h10 + k), 0, 0, 8'hFF, 8'hFF, 1, 8'(1 << (k - 1)),
                       8'(8'h10 + k - 1), 3'(k - 1), 0, 16'(k - 1), 8'd0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hFF, 8'hFF, 1, 8'h01, 8'h18, 3'd0, 0, 16'd8, 8'd0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hFF, 8'hFF, 1, 8'h00, 8'h18, 3'd0, 0, 16'd9, 8'd0));
    run_table("rr");

    // Skipping disabled channels, then fixed mode delivery and fixed-mode drop.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(1, 8'h20, 0, 0, 8'hA5, 8'hFF, 1, 8'h00, 8'h00, 3'd0, 0, 16'd0, 8'd0));
    tbl.push_back(mk(1, 8'h21, 0, 0, 8'hA5, 8'hFF, 1, 8'h01, 8'h20, 3'd0, 0, 16'd0, 8'd0));
    tbl.push_back(mk(1, 8'h22, 0, 0, 8'hA5, 8'hFF, 1, 8'h04, 8'h21, 3'd2, 0, 16'd1, 8'd0));
    tbl.push_back(mk(1, 8'h23, 0, 0, 8'hA5, 8'hFF, 1, 8'h20, 8'h22, 3'd5, 0, 16'd2, 8'd0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hA5, 8'hFF, 1, 8'h80, 8'h23, 3'd7, 0, 16'd3, 8'd0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hA5, 8'hFF, 1, 8'h00, 8'h23, 3'd7, 0, 16'd4, 8'd0));
    tbl.push_back(mk(1, 8'hA5, 3, 1, 8'hFF, 8'h00, 1, 8'h00, 8'h23, 3'd7, 0, 16'd4, 8'd0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 8'hFF, 8'hF7, 0, 8'h08, 8'hA5, 3'd3, 0, 16'd4, 8'd0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 8'hFF, 8'h08, 1, 8'h08, 8'hA5, 3'd3, 0, 16'd4, 8'd0));
    tbl.push_back(mk(1, 8'h5A, 3, 1, 8'hF7, 8'hFF, 1, 8'h00, 8'hA5, 3'd3, 0, 16'd5, 8'd0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hFF, 8'hFF, 1, 8'h00, 8'h5A, 3'd3, 1, 16'd5, 8'd1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'hFF, 8'hFF, 1, 8'h00, 8'h5A, 3'd3, 0, 16'd5, 8'd1));
    run_table("skipfix");

    // Timeout: drop exactly 16 cycles after out_valid rises, ptr then advances.
    do_reset();
    drive(1, 8'h77, 0, 0, 8'hFF, 8'h00);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("to.out_valid_rise", 32'(out_valid), 32'h01);
    n = 0;
    held_ok = 1'b1;
    while (!drop && n < 40) begin
      @(negedge clk);
      n++;
      if (!drop && out_valid !== 8'h01) held_ok = 1'b0;
    end
    chk("to.cycles_to_drop", 32'(n), 32'd16);
    chk("to.held_until_drop", 32'(held_ok), 32'h1);
    chk("to.out_valid_at_drop", 32'(out_valid), 32'h0);
    chk("to.drop_cnt", 32'(drop_cnt), 32'd1);
    chk("to.deliver_cnt", 32'(deliver_cnt), 32'd0);
    step();
    drive(1, 8'h78, 0, 0, 8'hFF, 8'hFF);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("to.ptr_advanced_sel", 32'(sel), 32'd1);
    chk("to.drop_cleared", 32'(drop), 32'h0);
    step();

    // Mode flip while a fixed-mode word is held must not move it or the pointer.
    drive(1, 8'h33, 3'd5, 1, 8'hFF, 8'h00);
    step();
    in_valid = 1'b0;
    mode = 1'b0;
    held_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (sel !== 3'd5 || out_valid !== 8'h20 || out_data !== 8'h33) held_ok = 1'b0;
      step();
    end
    chk("mode.held_stable", 32'(held_ok), 32'h1);
    out_ready = 8'hFF;
    step();
    drive(1, 8'h44, 0, 0, 8'hFF, 8'hFF);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mode.ptr_unchanged_sel", 32'(sel), 32'd2);
    chk("mode.out_valid", 32'(out_valid), 32'h04);
    step();
    @(negedge clk);
    chk("mode.deliver_cnt", 32'(deliver_cnt), 32'd3);
    step();

    // All channels disabled: no acceptance, pointer stays.
    drive(1, 8'h55, 0, 0, 8'h00, 8'hFF);
    held_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 8'h00) held_ok = 1'b0;
      step();
    end
    chk("zero_en.blocked", 32'(held_ok), 32'h1);
    chan_en = 8'hFF;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("zero_en.ptr_kept_sel", 32'(sel), 32'd3);
    chk("zero_en.out_data", 32'(out_data), 32'h55);
    step();

    // Reset mid-SEND: outputs clear at once, held word is not counted as dropped.
    do_reset();
    drive(1, 8'h66, 0, 0, 8'hFF, 8'h00);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst.pre_out_valid", 32'(out_valid), 32'h01);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.out_data", 32'(out_data), 32'h0);
    chk("rst.sel", 32'(sel), 32'h0);
    chk("rst.drop", 32'(drop), 32'h0);
    chk("rst.deliver_cnt", 32'(deliver_cnt), 32'h0);
    chk("rst.drop_cnt", 32'(drop_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    held_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (drop !== 1'b0 || drop_cnt !== 8'd0 || out_valid !== 8'h00) held_ok = 1'b0;
    end
    chk("rst.no_drop_after", 32'(held_ok), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning payload width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the number of cycles a held word waits for its destination before being dropped (must be ≥1).
REQ-003 SHALL have port clk  input  1  single clock, all state updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port in_sel  input  3  destination channel in fixed mode.
REQ-009 SHALL have port mode  input  1  0 = round-robin, 1 = fixed (in_sel).
REQ-010 SHALL have port chan_en  input  8  per-channel enable mask.
REQ-011 SHALL have port out_valid  output  8  one-hot valid per destination channel.
REQ-012 SHALL have port out_ready  input  8  per-channel destination ready.
REQ-013 SHALL have port out_data  output  DATA_W  held payload, shared by all channels.
REQ-014 SHALL have port sel  output  3  index of the currently targeted channel, for driving the 1:8 demux select.
REQ-015 SHALL have port drop  output  1  one-cycle pulse when a word is discarded.
REQ-016 SHALL have port deliver_cnt  output  16  count of delivered words, wraps at 65535->0.
REQ-017 SHALL have port drop_cnt  output  8  count of dropped words, saturates at 255.

Function
REQ-018 SHALL implement FSM states IDLE (no word held) and SEND (one word held in the output register).
REQ-019 SHALL assert in_ready = (state==IDLE or out_fire) and (|chan_en), where out_fire = |(out_valid & out_ready).
REQ-020 SHALL, on in_valid & in_ready, capture in_data and the target, and enter SEND; out_valid is asserted the next cycle (latency 1).
REQ-021 SHALL sample mode only at acceptance; a mode change while in SEND SHALL NOT affect the held word.
REQ-022 SHALL, in round-robin mode, select as target the first enabled channel at or after pointer ptr, searching upward with wrap 7->0.
REQ-023 SHALL, in fixed mode, use in_sel as the target; if chan_en[in_sel]=0, the word SHALL be accepted, dropped (drop pulse the next cycle), and the FSM SHALL stay in IDLE.
REQ-024 SHALL, in SEND, drive out_valid one-hot at the target and hold out_data and sel stable until handshake or timeout.
REQ-025 SHALL, on out_fire, increment deliver_cnt and, in round-robin mode, set ptr = target+1 (mod 8).
REQ-026 SHALL, on out_fire with a simultaneous accept, move directly SEND->SEND with the new word, giving full throughput of one word per cycle.
REQ-027 SHALL count SEND cycles without out_fire; when the count reaches TIMEOUT, it SHALL drop the word, pulse drop, increment drop_cnt, advance ptr as on delivery, and return to IDLE.
REQ-028 SHALL continue to hold a word whose channel is de-enabled during SEND; that word leaves only by handshake or timeout.
REQ-029 SHALL, when chan_en is all zeros, hold in_ready low and leave ptr unchanged.
REQ-030 SHALL assert out_valid only for out_ready bits matching the target; out_ready on other channels SHALL be ignored.

Reset
REQ-031 SHALL, when rst_n is low, immediately force: state IDLE, ptr 0, out_valid 0, out_data 0, sel 0, drop 0, deliver_cnt 0, drop_cnt 0, timeout counter 0.
REQ-032 SHALL discard any held word when reset is asserted mid-SEND, without pulsing drop and without counting it.

Structure
REQ-033 SHALL take N_CH=8, SEL_W=3 and the FSM state enum from shared package demux_pkg.
REQ-034 SHALL place the wrap-around first-enabled search (ptr, chan_en -> index, found) in sub-module demux_rr_pick.

Verification
REQ-035 SHALL cover round-robin: mode=0, chan_en=8'hFF, all out_ready=1, 8 words 0x10..0x17 -> delivered on channels 0..7 in order, then channel 0 again; deliver_cnt=8 after the eighth word.
REQ-036 SHALL cover skipping: chan_en=8'b1010_0101, ptr=0, 4 words -> delivered on channels 0, 2, 5, 7.
REQ-037 SHALL cover fixed mode: mode=1, in_sel=3'b011, data 0xA5 -> out_valid=8'b0000_1000, sel=3, out_data=0xA5; with chan_en[3]=0 -> drop pulse and drop_cnt+1.
REQ-038 SHALL cover timeout: TIMEOUT=16, out_ready=0 -> drop asserted exactly 16 cycles after out_valid rises, and ptr advanced.
REQ-039 SHALL cover back-to-back traffic: in_valid held high, out_ready=1 -> one delivery per cycle with no bubble.
REQ-040 SHALL cover reset: rst_n pulsed low mid-SEND -> all outputs 0 within the same cycle, drop_cnt unchanged (0).
